pc_fetch_ctrl: RTL and testbench
================================

# pc_fetch_ctrl

Sequencer for the program counter and instruction fetch stage. It owns the PC register and drives the select of the next-PC mux (redirect target vs. PC+4). It runs the request/acknowledge handshake to instruction memory and holds fetched instructions against hazard-unit stalls. It discards in-flight fetches when a branch or exception redirect arrives. It sits between instruction memory and the IF/ID boundary.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC loaded by reset
- EXC_VECTOR, 32'h0000_4180, PC loaded on exception redirect

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard unit: IF/ID output not consumed this cycle
- br_taken  in  1  EX-stage branch/jump redirect request
- br_target  in  32  redirect address; bits [1:0] ignored (forced 00)
- exc_req  in  1  exception redirect to EXC_VECTOR; priority over br_taken
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address
- imem_ack  in  1  memory returns imem_rdata for the outstanding request this cycle
- imem_rdata  in  32  fetched instruction
- pc_sel  out  1  next-PC mux select: 0 = redirect target, 1 = PC+4 (combinational)
- if_valid  out  1  if_pc/if_inst hold a valid instruction
- if_pc  out  32  PC of the presented instruction
- if_inst  out  32  presented instruction

## Operation
- Reset: pc=RESET_PC, state=BOOT, imem_req=0, if_valid=0, if_pc=0, if_inst=0, skid empty. pc_sel follows its combinational definition.
- States: BOOT, REQ, HOLD, DROP.
- Redirect = exc_req | br_taken. Target is EXC_VECTOR if exc_req, else {br_target[31:2],2'b00}. pc_sel = ~redirect.
- The slot is free when !if_valid || !stall. Downstream consumes the slot when if_valid && !stall.
- BOOT: imem_req=0. Always go to REQ next cycle. A redirect in BOOT loads the target into pc.
- REQ: imem_req=1, imem_addr=pc.
  - ack, no redirect, slot free: if_valid=1, if_pc=pc, if_inst=rdata, pc+=4, stay REQ.
  - ack, no redirect, slot not free: load the skid buffer {pc, rdata}, pc+=4, go to HOLD.
  - No ack, slot consumed with nothing new: if_valid=0.
- HOLD: imem_req=0. When !stall, move skid to the output and go to REQ.
- DROP: imem_req=1 with the old address held until ack. The returned data is discarded, then go to REQ.
- Redirect in any state:
  - pc<=target, if_valid<=0, skid cleared.
  - From REQ without ack in the same cycle: go to DROP.
  - From REQ with ack in the same cycle: discard the data, go to REQ.
  - From HOLD or BOOT: go to REQ.
  - In DROP: stay in DROP with the new target.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 = 0.
- rst mid-operation overrides everything, including an outstanding fetch. Memory must tolerate an abandoned request.

## Timing
- Memory protocol:
  - imem_addr stays stable while imem_req=1 and no ack.
  - imem_req falls only after ack, except on rst.
  - Ack may arrive in the same cycle as the request (zero-wait) or later.
  - Ack while imem_req=0 is illegal.
- Zero-wait memory, no stalls:
  - Cycle 0 after reset release is BOOT.
  - Cycle 1 is REQ at RESET_PC.
  - Cycle 2: if_valid=1, if_pc=RESET_PC.
  - Then one instruction per cycle.
- Redirect to issue: a redirect sampled at edge N puts the target on imem_addr in cycle N+1 (from REQ with ack, HOLD, or BOOT). From DROP, the target is issued the cycle after the discarded ack.
- Stall to resume: HOLD to output takes 1 cycle after stall falls. The next request issues in the same cycle the skid moves to the output.

## Test plan
- Reset release, zero-wait memory, no stall: imem_addr = 0x3000, 0x3004, 0x3008; if_pc follows one cycle later; pc_sel=1 throughout.
- Memory with 2-cycle ack latency: imem_addr held at 0x3004 for 3 cycles. Exactly one if_valid pulse per ack, with no duplicates.
- Stall for 3 cycles with an ack arriving during the stall: the output holds 0x3004, the skid holds 0x3008, imem_req=0. After stall falls, 0x3008 is presented, then a request goes out to 0x300C.
- br_taken with br_target=0x3101 while a request is outstanding:
  - pc_sel=0 that cycle, if_valid drops, state goes to DROP.
  - Ack data for the old address is never presented.
  - Next request address is 0x3100.
- exc_req and br_taken in the same cycle with the ack also in that cycle: the data is discarded and the next imem_addr is 0x4180.
- pc=0xFFFF_FFFC fetch acked: next imem_addr is 0x0000_0000. Then rst asserted mid-request: the next cycle shows BOOT outputs (imem_req=0, if_valid=0), followed by a request to 0x3000.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter and instruction-fetch sequencer.
// Owns the PC and the memory request/ack handshake. A one-entry skid
// absorbs an ack that lands while IF/ID is stalled. In-flight fetches
// are squashed on branch or exception redirects.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        pc_sel,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  typedef enum logic [1:0] {BOOT, REQ, HOLD, DROP} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_drop_addr;   // address of the squashed fetch still awaiting ack
  logic        r_imem_req;
  logic        r_if_valid;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_inst;
  logic [31:0] r_skid_pc;     // skid content is live exactly while in HOLD
  logic [31:0] r_skid_inst;

  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_slot_free;
  logic        w_consume;
  logic [31:0] w_pc_inc;

  assign w_redirect  = exc_req | br_taken;
  // Masking, rather than slicing, keeps every br_target bit in use.
  assign w_target    = exc_req ? EXC_VECTOR : (br_target & 32'hFFFF_FFFC);
  assign w_slot_free = !r_if_valid || !stall;
  assign w_consume   = r_if_valid && !stall;
  assign w_pc_inc    = r_pc + 32'd4;

  assign pc_sel    = ~w_redirect;
  assign imem_req  = r_imem_req;
  // DROP keeps the squashed fetch's address stable until its ack arrives.
  assign imem_addr = (r_state == DROP) ? r_drop_addr : r_pc;
  assign if_valid  = r_if_valid;
  assign if_pc     = r_if_pc;
  assign if_inst   = r_if_inst;

  // Fetch FSM: PC, handshake, IF/ID output register and skid buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= BOOT;
      r_pc        <= RESET_PC;
      r_drop_addr <= RESET_PC;
      r_imem_req  <= 1'b0;
      r_if_valid  <= 1'b0;
      r_if_pc     <= 32'd0;
      r_if_inst   <= 32'd0;
      r_skid_pc   <= 32'd0;
      r_skid_inst <= 32'd0;
    end else if (w_redirect) begin
      // Every redirect leaves a request on the bus: either the new target
      // or the squashed fetch that still needs its ack.
      r_pc       <= w_target;
      r_if_valid <= 1'b0;
      r_imem_req <= 1'b1;
      case (r_state)
        REQ: begin
          if (imem_ack) begin
            r_state <= REQ;
          end else begin
            r_state     <= DROP;
            r_drop_addr <= r_pc;
          end
        end
        // An ack landing with the redirect closes the old fetch, so the
        // new target can issue immediately.
        DROP:    r_state <= imem_ack ? REQ : DROP;
        default: r_state <= REQ;
      endcase
    end else begin
      case (r_state)
        BOOT: begin
          r_state    <= REQ;
          r_imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_ack) begin
            r_pc <= w_pc_inc;
            if (w_slot_free) begin
              r_if_valid <= 1'b1;
              r_if_pc    <= r_pc;
              r_if_inst  <= imem_rdata;
            end else begin
              r_skid_pc   <= r_pc;
              r_skid_inst <= imem_rdata;
              r_state     <= HOLD;
              r_imem_req  <= 1'b0;
            end
          end else if (w_consume) begin
            r_if_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            r_if_valid <= 1'b1;
            r_if_pc    <= r_skid_pc;
            r_if_inst  <= r_skid_inst;
            r_state    <= REQ;
            r_imem_req <= 1'b1;
          end
        end
        DROP: begin
          if (w_consume) r_if_valid <= 1'b0;
          if (imem_ack)  r_state    <= REQ;
        end
        default: r_state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: a per-cycle vector table for the main
// fetch/stall/branch flow, then hand sequences for exception priority,
// PC wraparound and mid-request reset.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, br_taken = 1'b0, exc_req = 1'b0, imem_ack = 1'b0;
  logic [31:0] br_target = '0, imem_rdata = '0;
  logic        imem_req, pc_sel, if_valid;
  logic [31:0] imem_addr, if_pc, if_inst;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .exc_req(exc_req), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc_sel(pc_sel), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
  );

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        exc;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_sel;
    logic        e_vld;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  function automatic vec_t mk(logic s, logic b, logic [31:0] t, logic x, logic a,
                              logic [31:0] d, logic er, logic [31:0] ea, logic es,
                              logic ev, logic [31:0] ep, logic [31:0] ei);
    vec_t v;
    v.stall = s; v.br = b; v.tgt = t; v.exc = x; v.ack = a; v.rdata = d;
    v.e_req = er; v.e_addr = ea; v.e_sel = es; v.e_vld = ev; v.e_pc = ep; v.e_inst = ei;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1ns later,
  // so the rising edge that follows consumes the inputs just checked.
  task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] t,
                       input logic x, input logic a, input logic [31:0] d);
    @(negedge clk);
    rst = r; stall = s; br_taken = b; br_target = t; exc_req = x;
    imem_ack = a; imem_rdata = d;
    #1;
  endtask

  vec_t tv[14];

  initial begin
    //             stall br tgt          exc ack rdata         req addr         sel vld pc           inst
    tv[0]  = mk(0, 0, 32'h0,       0, 0, 32'h0,         0, 32'h0,        1, 0, 32'h0,    32'h0);
    tv[1]  = mk(0, 0, 32'h0,       0, 1, 32'hA000_3000, 1, 32'h3000,     1, 0, 32'h0,    32'h0);
    tv[2]  = mk(0, 0, 32'h0,       0, 0, 32'h0,         1, 32'h3004,     1, 1, 32'h3000, 32'hA000_3000);
    tv[3]  = mk(0, 0, 32'h0,       0, 0, 32'h0,         1, 32'h3004,     1, 0, 32'h3000, 32'hA000_3000);
    tv[4]  = mk(0, 0, 32'h0,       0, 1, 32'hA000_3004, 1, 32'h3004,     1, 0, 32'h3000, 32'hA000_3000);
    tv[5]  = mk(1, 0, 32'h0,       0, 1, 32'hA000_3008, 1, 32'h3008,     1, 1, 32'h3004, 32'hA000_3004);
    tv[6]  = mk(1, 0, 32'h0,       0, 0, 32'h0,         0, 32'h0,        1, 1, 32'h3004, 32'hA000_3004);
    tv[7]  = mk(1, 0, 32'h0,       0, 0, 32'h0,         0, 32'h0,        1, 1, 32'h3004, 32'hA000_3004);
    tv[8]  = mk(0, 0, 32'h0,       0, 0, 32'h0,         0, 32'h0,        1, 1, 32'h3004, 32'hA000_3004);
    tv[9]  = mk(0, 1, 32'h3101,    0, 0, 32'h0,         1, 32'h300C,     0, 1, 32'h3008, 32'hA000_3008);
    tv[10] = mk(0, 0, 32'h0,       0, 0, 32'h0,         1, 32'h300C,     1, 0, 32'h3008, 32'hA000_3008);
    tv[11] = mk(0, 0, 32'h0,       0, 1, 32'hDEAD_BEEF, 1, 32'h300C,     1, 0, 32'h3008, 32'hA000_3008);
    tv[12] = mk(0, 0, 32'h0,       0, 1, 32'hA000_3100, 1, 32'h3100,     1, 0, 32'h3008, 32'hA000_3008);
    tv[13] = mk(0, 0, 32'h0,       0, 0, 32'h0,         1, 32'h3104,     1, 1, 32'h3100, 32'hA000_3100);

    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Reset release, zero-wait fetch, latency-2 ack, stall with skid, branch squash.
    for (int i = 0; i < 14; i++) begin
      drive(1'b0, tv[i].stall, tv[i].br, tv[i].tgt, tv[i].exc, tv[i].ack, tv[i].rdata);
      chk($sformatf("v%0d imem_req", i), {31'd0, imem_req}, {31'd0, tv[i].e_req});
      if (tv[i].e_req) chk($sformatf("v%0d imem_addr", i), imem_addr, tv[i].e_addr);
      chk($sformatf("v%0d pc_sel", i),   {31'd0, pc_sel},   {31'd0, tv[i].e_sel});
      chk($sformatf("v%0d if_valid", i), {31'd0, if_valid}, {31'd0, tv[i].e_vld});
      chk($sformatf("v%0d if_pc", i),    if_pc,   tv[i].e_pc);
      chk($sformatf("v%0d if_inst", i),  if_inst, tv[i].e_inst);
    end

    // Exception and branch together, ack in the same cycle: exception wins, data dropped.
    drive(1'b0, 1'b0, 1'b1, 32'h5000, 1'b1, 1'b1, 32'hBAD0_BAD0);
    chk("exc pc_sel", {31'd0, pc_sel}, 32'd0);
    chk("exc old addr", imem_addr, 32'h3104);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA000_4180);
    chk("exc req", {31'd0, imem_req}, 32'd1);
    chk("exc addr", imem_addr, 32'h4180);
    chk("exc squash vld", {31'd0, if_valid}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("exc vld", {31'd0, if_valid}, 32'd1);
    chk("exc if_pc", if_pc, 32'h4180);
    chk("exc if_inst", if_inst, 32'hA000_4180);
    chk("exc next addr", imem_addr, 32'h4184);

    // Branch to the top of memory (low bits ignored), wrap to 0, then reset mid-request.
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1, 32'hBAD1_BAD1);
    chk("wrap br pc_sel", {31'd0, pc_sel}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA0FF_FFFC);
    chk("wrap top addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap top vld", {31'd0, if_valid}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("wrap addr0", imem_addr, 32'h0000_0000);
    chk("wrap req", {31'd0, imem_req}, 32'd1);
    chk("wrap if_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap if_inst", if_inst, 32'hA0FF_FFFC);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("rst req", {31'd0, imem_req}, 32'd0);
    chk("rst vld", {31'd0, if_valid}, 32'd0);
    chk("rst if_pc", if_pc, 32'd0);
    chk("rst if_inst", if_inst, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("rst restart req", {31'd0, imem_req}, 32'd1);
    chk("rst restart addr", imem_addr, 32'h3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
